// File: rtl/rsa_ctrl.sv
// ----------------------------------------------------------------------------
// rsa_ctrl : operand loader and launch/capture sequencer for rsa_unit.
// Optional RUN timeout enabled by defining RSA_CTRL_TIMEOUT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rsa_ctrl #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             wr_valid,
  input  logic [1:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [15:0]      run_cycles,
  output logic             rsa_en,
  output logic [WIDTH-1:0] rsa_P,
  output logic [WIDTH-1:0] rsa_E,
  output logic [WIDTH-1:0] rsa_M,
  output logic [WIDTH-1:0] rsa_Const,
  input  logic             rsa_eoc,
  input  logic [WIDTH-1:0] rsa_C
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

`ifdef RSA_CTRL_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
`endif

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rsa_en_q, rsa_en_d;
  logic             eoc_q, eoc_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] const_q, const_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      run_cycles_q, run_cycles_d;

  logic             eoc_rise;
  logic             wr_ok;
  logic [15:0]      cnt_inc;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    rsa_en_d     = rsa_en_q;
    eoc_d        = rsa_eoc;
    p_d          = p_q;
    e_d          = e_q;
    m_d          = m_q;
    const_d      = const_q;
    result_d     = result_q;
    cnt_d        = cnt_q;
    run_cycles_d = run_cycles_q;

    eoc_rise = rsa_eoc & ~eoc_q;
    cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    wr_ok    = ena & wr_valid & (state_q == S_IDLE);

    // Operands only move while idle, so the core never sees them change mid-run.
    if (wr_ok) begin
      case (wr_sel)
        2'd0:    p_d     = wr_data;
        2'd1:    e_d     = wr_data;
        2'd2:    m_d     = wr_data;
        default: const_d = wr_data;
      endcase
    end

    if (!ena) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      rsa_en_d = 1'b0;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_ARM;
            busy_d   = 1'b1;
            rsa_en_d = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b0;
            cnt_d    = 16'd0;
          end
        end
        S_ARM: begin
          state_d  = S_RUN;
          rsa_en_d = 1'b1;
        end
        S_RUN: begin
          cnt_d = cnt_inc;
          if (eoc_rise) begin
            result_d     = rsa_C;
            run_cycles_d = cnt_inc;
            done_d       = 1'b1;
            busy_d       = 1'b0;
            rsa_en_d     = 1'b0;
            state_d      = S_IDLE;
          end
`ifdef RSA_CTRL_TIMEOUT_EN
          else if (cnt_inc >= TMO_LIMIT) begin
            result_d     = '0;
            run_cycles_d = TMO_LIMIT;
            err_d        = 1'b1;
            done_d       = 1'b1;
            busy_d       = 1'b0;
            rsa_en_d     = 1'b0;
            state_d      = S_IDLE;
          end
`endif
        end
        default: begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          rsa_en_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rsa_en_q     <= 1'b0;
      eoc_q        <= 1'b0;
      p_q          <= '0;
      e_q          <= '0;
      m_q          <= '0;
      const_q      <= '0;
      result_q     <= '0;
      cnt_q        <= 16'd0;
      run_cycles_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rsa_en_q     <= rsa_en_d;
      eoc_q        <= eoc_d;
      p_q          <= p_d;
      e_q          <= e_d;
      m_q          <= m_d;
      const_q      <= const_d;
      result_q     <= result_d;
      cnt_q        <= cnt_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rsa_en     = rsa_en_q;
  assign result     = result_q;
  assign run_cycles = run_cycles_q;
  assign rsa_P      = p_q;
  assign rsa_E      = e_q;
  assign rsa_M      = m_q;
  assign rsa_Const  = const_q;

endmodule

`default_nettype wire

// File: tb/tb_rsa_ctrl.sv
// Directed + randomized bench for rsa_ctrl with a behavioural core/operand model.
`timescale 1ns/1ps
`default_nettype none

module tb_rsa_ctrl;
  localparam int W   = 8;
  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b0;
  logic         wr_valid = 1'b0;
  logic [1:0]   wr_sel = 2'd0;
  logic [W-1:0] wr_data = '0;
  logic         start = 1'b0;
  logic         rsa_eoc = 1'b0;
  logic [W-1:0] rsa_C = '0;

  logic         busy, done, err, rsa_en;
  logic [W-1:0] result, rsa_P, rsa_E, rsa_M, rsa_Const;
  logic [15:0]  run_cycles;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_ops [4];
  logic [W-1:0] m_result;
  logic [15:0]  m_cycles;

  always #5 clk = ~clk;

  rsa_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .err(err),
    .result(result), .run_cycles(run_cycles), .rsa_en(rsa_en),
    .rsa_P(rsa_P), .rsa_E(rsa_E), .rsa_M(rsa_M), .rsa_Const(rsa_Const),
    .rsa_eoc(rsa_eoc), .rsa_C(rsa_C)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ops(input string tag);
    check({tag, "_P"}, 32'(rsa_P), 32'(m_ops[0]));
    check({tag, "_E"}, 32'(rsa_E), 32'(m_ops[1]));
    check({tag, "_M"}, 32'(rsa_M), 32'(m_ops[2]));
    check({tag, "_Const"}, 32'(rsa_Const), 32'(m_ops[3]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_en"}, 32'(rsa_en), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_cycles"}, 32'(run_cycles), 0);
    check_ops(tag);
  endtask

  // One host write; the model records it only when the controller should accept it.
  task automatic wr(input logic [1:0] sel, input logic [W-1:0] d, input bit accept);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    if (accept) m_ops[sel] = d;
  endtask

  // start sampled at edge T: ARM after T, RUN (en high) after T+1.
  task automatic launch(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_arm_busy"}, 32'(busy), 1);
    check({tag, "_arm_en"}, 32'(rsa_en), 0);
    tick();
    check({tag, "_run_en"}, 32'(rsa_en), 1);
  endtask

  // Core model: eoc is first sampled high on RUN edge n; 'used' RUN edges already elapsed.
  task automatic finish_run(input string tag, input int n, input int used, input logic [W-1:0] c);
    repeat (n - 1 - used) tick();
    rsa_eoc = 1'b1;
    rsa_C   = c;
    tick();
    m_result = c;
    m_cycles = 16'(n);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_result"}, 32'(result), 32'(m_result));
    check({tag, "_cycles"}, 32'(run_cycles), 32'(m_cycles));
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_en"}, 32'(rsa_en), 0);
    check({tag, "_err"}, 32'(err), 0);
    rsa_eoc = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_ops[i] = '0;
    m_result = '0;
    m_cycles = 16'd0;

    // Reset
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();

    // Load and run
    wr(2'd0, 8'h0D, 1'b1);
    wr(2'd1, 8'h05, 1'b1);
    wr(2'd2, 8'h07, 1'b1);
    wr(2'd3, 8'h03, 1'b1);
    check_ops("load");
    launch("run1");
    finish_run("run1", 20, 0, 8'h5A);

    // Frozen operands, start ignored while busy
    launch("frz");
    start = 1'b1;
    wr(2'd2, 8'hFF, 1'b0);
    start = 1'b0;
    check("frz_M", 32'(rsa_M), 32'(m_ops[2]));
    check("frz_busy", 32'(busy), 1);
    finish_run("frz", 9, 1, 8'h5A);
    check_ops("frz_after");

    // Same-cycle write and start
    wr_valid = 1'b1; wr_sel = 2'd1; wr_data = 8'h11; start = 1'b1;
    tick();
    wr_valid = 1'b0; start = 1'b0;
    m_ops[1] = 8'h11;
    check("same_E", 32'(rsa_E), 32'h11);
    check("same_en", 32'(rsa_en), 0);
    tick();
    check("same_run_en", 32'(rsa_en), 1);
    finish_run("same", 5, 0, 8'hC3);

    // Back-to-back: done lasts one cycle when start is held
    start = 1'b1;
    tick();
    check("b2b_done", 32'(done), 0);
    check("b2b_busy", 32'(busy), 1);
    start = 1'b0;
    tick();
    check("b2b_en", 32'(rsa_en), 1);
    finish_run("b2b", 7, 0, 8'h3C);

    // ena low clears done and keeps results
    ena = 1'b0;
    tick();
    check("enoff_done", 32'(done), 0);
    check("enoff_result", 32'(result), 32'(m_result));
    wr(2'd0, 8'hAA, 1'b0);
    check_ops("enoff_wr");
    ena = 1'b1;
    tick();

    // Abort mid-run, late eoc ignored
    launch("abort");
    repeat (5) tick();
    ena = 1'b0;
    tick();
    ena = 1'b1;
    check("abort_busy", 32'(busy), 0);
    check("abort_en", 32'(rsa_en), 0);
    check("abort_done", 32'(done), 0);
    tick();
    rsa_eoc = 1'b1;
    rsa_C   = 8'hEE;
    tick();
    tick();
    check("abort_late_done", 32'(done), 0);
    check("abort_result", 32'(result), 32'(m_result));
    check("abort_cycles", 32'(run_cycles), 32'(m_cycles));
    check("abort_busy2", 32'(busy), 0);

    // eoc already high on RUN entry: no completion until a real rising edge
    launch("eochi");
    repeat (10) tick();
    check("eochi_busy", 32'(busy), 1);
    check("eochi_done", 32'(done), 0);
    rsa_eoc = 1'b0;
    tick();
    finish_run("eochi", 12, 11, 8'h77);

`ifdef RSA_CTRL_TIMEOUT_EN
    launch("tmo");
    repeat (TMO - 1) tick();
    check("tmo_pre_busy", 32'(busy), 1);
    check("tmo_pre_err", 32'(err), 0);
    tick();
    m_result = '0;
    m_cycles = 16'(TMO);
    check("tmo_err", 32'(err), 1);
    check("tmo_done", 32'(done), 1);
    check("tmo_result", 32'(result), 0);
    check("tmo_cycles", 32'(run_cycles), TMO);
    check("tmo_busy", 32'(busy), 0);
    launch("tmo_tie");
    check("tmo_err_clr", 32'(err), 0);
    finish_run("tmo_tie", TMO, 0, 8'h99);
`else
    launch("notmo");
    repeat (100) tick();
    check("notmo_busy", 32'(busy), 1);
    check("notmo_err", 32'(err), 0);
    finish_run("notmo", 130, 100, 8'h99);
`endif

    // Randomized operand loads and runs
    for (int it = 0; it < 6; it++) begin
      int n;
      for (int s = 0; s < 4; s++) wr(2'(s), W'($urandom), 1'b1);
      check_ops("rnd_ops");
      n = int'($urandom_range(1, 40));
      launch("rnd");
      finish_run("rnd", n, 0, W'($urandom));
    end

    // Asynchronous reset mid-run
    launch("arst");
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) m_ops[i] = '0;
    check_all_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_idle_busy", 32'(busy), 0);
    wr(2'd3, 8'h42, 1'b1);
    check_ops("arst_wr");
    launch("arst_run");
    finish_run("arst_run", 3, 0, 8'h24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
